// File: rtl/regfile_np_pkg.sv
// regfile_np_pkg: shared defaults for the parametrised register file
package regfile_np_pkg;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_N_RD = 2;
   localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_np_scoreboard.sv
// regfile_np_scoreboard: per-register busy bits, set by mark and cleared by writeback
module regfile_np_scoreboard
   import regfile_np_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   WriteEnable0,
   input  logic [ADDR_W-1:0]      WriteAddr0,
   input  logic                   WriteEnable1,
   input  logic [ADDR_W-1:0]      WriteAddr1,
   input  logic                   MarkEnable,
   input  logic [ADDR_W-1:0]      MarkAddr,
   output logic [2**ADDR_W-1:0]   BusyVec
);
   logic [2**ADDR_W-1:0] busy, busyNext;
   always_comb begin
      busyNext = busy;
      if (WriteEnable0) busyNext[WriteAddr0] = 1'b0;
      if (WriteEnable1) busyNext[WriteAddr1] = 1'b0;
      if (MarkEnable) busyNext[MarkAddr] = 1'b1;
      if (ZERO_REG != 0) busyNext[REG_ZERO] = 1'b0;
   end
   always_ff @(posedge Clk)
      busy <= Rst ? '0 : busyNext;
   assign BusyVec = busy;
endmodule

// File: rtl/regfile_np.sv
// regfile_np: multi-port register file with two write ports, optional bypass and busy scoreboard
module regfile_np
   import regfile_np_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int N_RD = DEF_N_RD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS = 1
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     WriteEnable0,
   input  logic [ADDR_W-1:0]        WriteAddr0,
   input  logic [DATA_W-1:0]        WriteData0,
   input  logic                     WriteEnable1,
   input  logic [ADDR_W-1:0]        WriteAddr1,
   input  logic [DATA_W-1:0]        WriteData1,
   input  logic [N_RD*ADDR_W-1:0]   ReadAddr,
   output logic [N_RD*DATA_W-1:0]   ReadData,
   output logic [N_RD-1:0]          ReadBusy,
   input  logic                     MarkEnable,
   input  logic [ADDR_W-1:0]        MarkAddr,
   output logic [2**ADDR_W-1:0]     BusyVec
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] regs [DEPTH];
   logic keep0, keep1;
   if (N_RD < 1 || N_RD > 4) begin : gNrdCheck
      $error("regfile_np: N_RD must be in 1..4");
   end
   assign keep0 = WriteEnable0 && !(ZERO_REG != 0 && WriteAddr0 == ADDR_W'(REG_ZERO));
   assign keep1 = WriteEnable1 && !(ZERO_REG != 0 && WriteAddr1 == ADDR_W'(REG_ZERO));
   // port 1 is assigned last so it wins an address collision
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         if (keep0) regs[WriteAddr0] <= WriteData0;
         if (keep1) regs[WriteAddr1] <= WriteData1;
      end
   end
   regfile_np_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) uScoreboard (
      .Clk(Clk),
      .Rst(Rst),
      .WriteEnable0(WriteEnable0),
      .WriteAddr0(WriteAddr0),
      .WriteEnable1(WriteEnable1),
      .WriteAddr1(WriteAddr1),
      .MarkEnable(MarkEnable),
      .MarkAddr(MarkAddr),
      .BusyVec(BusyVec)
   );
   for (genvar k = 0; k < N_RD; k++) begin : gRead
      logic [ADDR_W-1:0] ra;
      assign ra = ReadAddr[k*ADDR_W +: ADDR_W];
      assign ReadData[k*DATA_W +: DATA_W] =
         (ZERO_REG != 0 && ra == ADDR_W'(REG_ZERO)) ? '0 :
         (BYPASS != 0 && WriteEnable1 && WriteAddr1 == ra) ? WriteData1 :
         (BYPASS != 0 && WriteEnable0 && WriteAddr0 == ra) ? WriteData0 : regs[ra];
      // busy is registered state only; a same-cycle write does not clear it early
      assign ReadBusy[k] = BusyVec[ra];
   end
endmodule
